// File: rtl/sram_dp_ctrl.sv
// Simple dual-port RAM with per-byte write enables, write-first forwarding and a clear sweep.
// Optional SRAM_OUTREG_EN adds a second output register stage (read latency 2).
module sram_dp_ctrl #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 1024,
    parameter int                ADDR_W    = 10,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CS_N,
    input  logic                  WR_N,
    input  logic                  RD_N,
    input  logic [DATA_W/8-1:0]   BE_N,
    input  logic [ADDR_W-1:0]     WRADDR,
    input  logic [ADDR_W-1:0]     RDADDR,
    input  logic [DATA_W-1:0]     WRDATA,
    input  logic                  CLR,
    output logic [DATA_W-1:0]     RDDATA,
    output logic                  RDVALID,
    output logic                  INIT_BUSY
);

    localparam int                LANES    = DATA_W / 8;
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               wr_en, rd_en, wr_hit;
    logic               wr_in_range, rd_in_range;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [DATA_W-1:0]  rd_next;
    logic [DATA_W-1:0]  rd_data_s1;
    logic               rd_valid_s1;

    assign wr_in_range = ({1'b0, WRADDR} < DEPTH_C);
    assign rd_in_range = ({1'b0, RDADDR} < DEPTH_C);
    assign wr_idx      = WRADDR[IDX_W-1:0];
    assign rd_idx      = RDADDR[IDX_W-1:0];

    assign wr_en  = !CS_N && !WR_N && (state_q == ST_IDLE) && wr_in_range;
    assign rd_en  = !CS_N && !RD_N && (state_q == ST_IDLE);
    assign wr_hit = wr_en && (WRADDR == RDADDR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // CLR restarts the sweep from either state; the sweep owns the array until it finishes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (CLR) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (CLR) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign INIT_BUSY = (state_q == ST_CLEAR);

    always_ff @(posedge CLK) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= CLEAR_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (!BE_N[i]) mem[wr_idx][8*i +: 8] <= WRDATA[8*i +: 8];
            end
        end
    end

    // Write-first: lanes being written this cycle at the read address return the new data.
    always_comb begin
        rd_next = '0;
        if (rd_in_range) begin
            for (int i = 0; i < LANES; i++) begin
                rd_next[8*i +: 8] = (wr_hit && !BE_N[i]) ? WRDATA[8*i +: 8]
                                                        : mem[rd_idx][8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_s1  <= '0;
            rd_valid_s1 <= 1'b0;
        end else begin
            rd_data_s1  <= rd_en ? rd_next : '0;
            rd_valid_s1 <= rd_en;
        end
    end

`ifdef SRAM_OUTREG_EN
    logic [DATA_W-1:0] rd_data_s2;
    logic              rd_valid_s2;

    // Stage 1 already carries zero/invalid throughout CLEAR, so copying it flushes this stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_s2  <= '0;
            rd_valid_s2 <= 1'b0;
        end else begin
            rd_data_s2  <= rd_data_s1;
            rd_valid_s2 <= rd_valid_s1;
        end
    end

    assign RDDATA  = rd_data_s2;
    assign RDVALID = rd_valid_s2;
`else
    assign RDDATA  = rd_data_s1;
    assign RDVALID = rd_valid_s1;
`endif

endmodule

// File: tb/tb_sram_dp_ctrl.sv
// Self-checking bench for sram_dp_ctrl: reference array model plus expected-output queue.
// Build with SRAM_OUTREG_EN defined to exercise the two-stage output variant.
module tb_sram_dp_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 11;
    localparam int LANES  = DATA_W / 8;
    localparam logic [DATA_W-1:0] CLEAR_VAL = 16'h0000;
`ifdef SRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, clr = 1'b0;
    logic [LANES-1:0]  be_n = '1;
    logic [ADDR_W-1:0] wraddr = '0, rdaddr = '0;
    logic [DATA_W-1:0] wrdata = '0;
    logic [DATA_W-1:0] rddata;
    logic              rdvalid, init_busy;

    sram_dp_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_VAL(CLEAR_VAL)
    ) dut (
        .CLK(clk), .RST(rst), .CS_N(cs_n), .WR_N(wr_n), .RD_N(rd_n), .BE_N(be_n),
        .WRADDR(wraddr), .RDADDR(rdaddr), .WRDATA(wrdata), .CLR(clr),
        .RDDATA(rddata), .RDVALID(rdvalid), .INIT_BUSY(init_busy)
    );

    always #5 clk = ~clk;

    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    bit                m_clear;
    int                m_cnt;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict the read result, clock, update the model, compare the oldest prediction.
    task automatic step();
        logic [DATA_W:0] e;
        e = '0;
        if (!m_clear && !cs_n && !rd_n) begin
            e[DATA_W] = 1'b1;
            if (int'(rdaddr) < DEPTH) begin
                for (int i = 0; i < LANES; i++) begin
                    if (!wr_n && wraddr == rdaddr && !be_n[i])
                        e[8*i +: 8] = wrdata[8*i +: 8];
                    else
                        e[8*i +: 8] = model[rdaddr][8*i +: 8];
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (m_clear) begin
            model[m_cnt] = CLEAR_VAL;
            if (clr) m_cnt = 0;
            else if (m_cnt == DEPTH - 1) m_clear = 1'b0;
            else m_cnt++;
        end else begin
            if (!cs_n && !wr_n && int'(wraddr) < DEPTH) begin
                for (int i = 0; i < LANES; i++)
                    if (!be_n[i]) model[wraddr][8*i +: 8] = wrdata[8*i +: 8];
            end
            if (clr) begin
                m_clear = 1'b1;
                m_cnt   = 0;
            end
        end
        #1;
        e = exp_q.pop_front();
        check("rdvalid", {31'd0, rdvalid}, {31'd0, e[DATA_W]});
        check("rddata", {16'd0, rddata}, {16'd0, e[DATA_W-1:0]});
        check("init_busy", {31'd0, init_busy}, {31'd0, m_clear});
    endtask

    task automatic op(input bit w, input bit r, input int wa, input logic [DATA_W-1:0] d,
                      input logic [LANES-1:0] be, input int ra, input bit c);
        cs_n   = 1'b0;
        wr_n   = !w;
        rd_n   = !r;
        wraddr = ADDR_W'(wa);
        wrdata = d;
        be_n   = be;
        rdaddr = ADDR_W'(ra);
        clr    = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; be_n = '1; clr = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_rddata", {16'd0, rddata}, 32'd0);
        check("rst_rdvalid", {31'd0, rdvalid}, 32'd0);
        check("rst_busy", {31'd0, init_busy}, 32'd1);
        exp_q.delete();
        m_clear = 1'b1;
        m_cnt   = 0;
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; be_n = '1; clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
    endtask

    // Counts DUT cycles with INIT_BUSY high, bounded so a stuck sweep still reaches the summary.
    task automatic sweep_len(input string tag);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 3000) begin
            idle(1);
            n++;
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        do_reset();
        sweep_len("sweep_len_reset");

        op(0, 1, 0, 0, '1, 0, 0);
        op(0, 1, 0, 0, '1, 511, 0);
        op(0, 1, 0, 0, '1, 1023, 0);
        idle(LAT + 1);

        op(1, 0, 5, 16'hBEEF, 2'b00, 0, 0);
        op(1, 0, 5, 16'h0012, 2'b10, 0, 0);
        op(0, 1, 0, 0, '1, 5, 0);
        idle(LAT);

        op(1, 0, 7, 16'h1111, 2'b00, 0, 0);
        op(1, 1, 7, 16'hA5A5, 2'b10, 7, 0);
        op(1, 0, 8, 16'h2222, 2'b00, 0, 0);
        op(1, 1, 8, 16'hA5A5, 2'b01, 8, 0);
        op(1, 1, 9, 16'hC3C3, 2'b00, 8, 0);
        idle(LAT);

        for (int i = 0; i < 300; i++) begin
            cs_n   = ($urandom_range(0, 4) == 0);
            wr_n   = $urandom_range(0, 1);
            rd_n   = $urandom_range(0, 1);
            be_n   = LANES'($urandom_range(0, 3));
            wraddr = ($urandom_range(0, 9) == 0) ? ADDR_W'(DEPTH + $urandom_range(0, 15))
                                                 : ADDR_W'($urandom_range(0, 15));
            rdaddr = ($urandom_range(0, 9) == 0) ? ADDR_W'(DEPTH + $urandom_range(0, 15))
                                                 : ADDR_W'($urandom_range(0, 15));
            wrdata = DATA_W'($urandom);
            clr    = 1'b0;
            step();
        end
        idle(LAT);

        for (int a = 0; a < 4; a++) op(1, 0, a, 16'hFFFF, 2'b00, 0, 0);
        op(0, 1, 0, 0, '1, 2, 1);
        op(1, 1, 0, 16'h1234, 2'b00, 0, 0);
        idle(100);
        op(0, 0, 0, 0, '1, 0, 1);
        sweep_len("sweep_len_restart");
        for (int a = 0; a < 4; a++) op(0, 1, 0, 0, '1, a, 0);
        idle(LAT);

        op(1, 0, 1030, 16'h5A5A, 2'b00, 0, 0);
        op(0, 1, 0, 0, '1, 1030, 0);
        op(0, 1, 0, 0, '1, 6, 0);
        idle(LAT);

        op(1, 0, 1, 16'h0101, 2'b00, 0, 0);
        op(1, 0, 2, 16'h0202, 2'b00, 0, 0);
        op(1, 0, 3, 16'h0303, 2'b00, 0, 0);
        op(0, 1, 0, 0, '1, 1, 0);
        op(0, 1, 0, 0, '1, 2, 0);
        op(0, 1, 0, 0, '1, 3, 0);
        op(0, 1, 0, 0, '1, 1, 0);
        #2;
        do_reset();
        sweep_len("sweep_len_midrst");
        op(0, 1, 0, 0, '1, 2, 0);
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
